// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a bus master and the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter with a valid/ready byte input.
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input logic SystemClk,
  input logic reset,
  uart_tx_if.slave bus,
  output logic TX,
  output logic tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CB = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CB-1:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] shift, shift_d;
  logic tx_d, pop, push, last;
  assign bus.tx_ready = fifo_count < (PW+1)'(FIFO_DEPTH);
  assign push = bus.tx_valid && bus.tx_ready;
  assign last = cnt == CB'(CLKS_PER_BIT - 1);
  assign tx_busy = state != IDLE || fifo_count != '0;
  always_comb begin
    state_d = state;
    cnt_d = last ? '0 : cnt + 1'b1;
    idx_d = idx;
    shift_d = shift;
    tx_d = TX;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (fifo_count != '0) begin
          pop = 1'b1;
          shift_d = mem[rptr];
          tx_d = 1'b0;
          state_d = START;
        end
      end
      START: if (last) begin
        tx_d = shift[0];
        idx_d = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        shift_d = shift >> 1;
        idx_d = idx + 1'b1;
        tx_d = idx == 3'd7 ? 1'b1 : shift[1];
        state_d = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (last) begin
        // back-to-back frames reload straight from the stop bit, no idle gap
        pop = fifo_count != '0;
        shift_d = pop ? mem[rptr] : shift;
        tx_d = !pop;
        state_d = pop ? START : IDLE;
      end
    endcase
  end
  always_ff @(posedge SystemClk) begin
    if (reset) begin
      state <= IDLE;
      TX <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_d;
      TX <= tx_d;
      cnt <= cnt_d;
      idx <= idx_d;
      shift <= shift_d;
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge SystemClk) if (push && !reset) mem[wptr] <= bus.tx_data;
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit counterpart of the CPU's UART receive path.
- Accepts bytes from the CPU/peripheral bus through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte on TX as an 8N1 frame: start bit 0, 8 data bits LSB first, stop bit 1. Line idles high.
- Sits beside the receiver in the CPU top; its TX drives the board TX pin.

Parameters:
- CLK_FREQ, 50000000: SystemClk frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division): clock cycles per bit time. Must be >= 2.
- FIFO_DEPTH, 4: byte buffer depth. Must be a power of 2, >= 2.

Ports:
- SystemClk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept; combinational, equals (fifo_count < FIFO_DEPTH).
- TX  out  1  serial line, registered.
- tx_busy  out  1  high when the state is not IDLE or fifo_count != 0.
- fifo_count  out  log2(FIFO_DEPTH)+1  bytes currently in the FIFO (excludes the byte being shifted).

Behaviour:
- Reset values (sampled at a rising edge with reset=1): TX=1, state=IDLE, fifo_count=0, read/write pointers=0, baud counter=0, bit index=0. This gives tx_ready=1 and tx_busy=0. Reset overrides all other activity, including mid-frame; no partial byte or stop bit is completed after reset.
- Push: when tx_valid && tx_ready at an edge, tx_data is written at wptr, wptr increments (wraps modulo FIFO_DEPTH), and count increments.
- Full FIFO: when count == FIFO_DEPTH, tx_ready=0 and tx_valid is ignored. No overwrite, no error flag.
- Simultaneous push and pop at one edge: count is unchanged and both pointers advance. tx_ready is based on the pre-edge count, so a push to a full FIFO is rejected even if a pop happens in the same cycle.
- States:
  - IDLE: TX=1. If count != 0: pop the head into the 8-bit shift register, set TX=0, clear the baud counter, go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then TX=shift[0], bit index=0, go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the index. After bit 7, TX=1 and go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the last cycle: if count != 0, pop, TX=0, go to START (back-to-back, zero idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; every TX level is held exactly CLKS_PER_BIT cycles.
- A frame is exactly 10*CLKS_PER_BIT cycles.
- Latency: a byte accepted at edge E0 into an empty FIFO while IDLE pops at E1, and TX falls after E1.
- tx_data is captured only at the push edge; later changes to tx_data have no effect.
- The shifting byte is held in the shift register, not the FIFO, so with a full FIFO the block holds FIFO_DEPTH+1 bytes in flight.

Test Plan:
- Reset: assert reset for 2 edges, with tx_valid=1 throughout -> TX=1, tx_ready=1, tx_busy=0, fifo_count=0, and nothing transmitted after reset is released with tx_valid=0.
- Single byte (CLK_FREQ=16, BAUD=1, so 16 cycles/bit): push 0x48 -> TX falls 1 cycle after the push edge. Bit sequence is 0,0,0,0,1,0,0,1,0,1, each bit 16 cycles. tx_busy drops exactly 160 cycles after TX falls.
- Back-to-back: push 0x12, 0x0C, 0xFF on consecutive cycles -> three contiguous frames totalling 480 cycles, no idle cycles between stop and start bits, fifo_count sequence 1,1,2 then decrementing at each frame start.
- Overflow: assert tx_valid for 7 consecutive cycles with bytes 0x01..0x07 from IDLE -> bytes 0x01..0x05 accepted (1 shifting + 4 buffered), tx_ready=0 from cycle 6, 0x06/0x07 never transmitted. tx_ready returns to 1 at the first pop after 0x01's stop bit.
- Reset mid-frame: assert reset during bit 3 of 0x5A with 2 bytes queued -> TX=1 after that edge, fifo_count=0, no further start bits after reset is released.
- Loopback at defaults (50 MHz, 9600 baud): TX wired to the existing UART receiver, send 0x12 then 0x0C -> the receiver reports 0x12 then 0x0C with no framing errors.
